gray_track_monitor: RTL
=======================

GRAY_TRACK_MONITOR -- requirements
Module: gray_track_monitor

Interface
REQ-001 SHALL have parameter W, default 4, meaning Gray/binary word width.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning number of input synchronizer flops (legal 2..4).
REQ-003 SHALL have parameter CNT_W, default 8, meaning error counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port G  input  W  Gray-coded position word from the upstream Gray encoder, may change asynchronously.
REQ-007 SHALL have port clr_err  input  1  synchronous clear of err_cnt.
REQ-008 SHALL have port B  output  W  registered decoded binary value.
REQ-009 SHALL have port B_valid  output  1  one-cycle pulse when B is updated.
REQ-010 SHALL have port dir  output  1  direction of last legal step (1 = up, 0 = down).
REQ-011 SHALL have port step_err  output  1  one-cycle pulse on an illegal (multi-step) change.
REQ-012 SHALL have port err_cnt  output  CNT_W  saturating count of illegal changes.
REQ-013 SHALL have port locked  output  1  high once the state machine is in TRACK.

Function
REQ-014 SHALL pass G through SYNC_STAGES flops; only the last stage (gs) feeds logic.
REQ-015 SHALL decode gs to binary bn: bn[W-1] = gs[W-1], bn[i] = bn[i+1] XOR gs[i] for i = W-2 down to 0.
REQ-016 SHALL implement FSM with states INIT and TRACK.
REQ-017 In INIT, SHALL count fill cycles 0..SYNC_STAGES; when the count reaches SYNC_STAGES, SHALL load B <= bn, pulse B_valid, leave dir unchanged, no error check, and go to TRACK.
REQ-018 In TRACK with bn == B, SHALL hold all outputs; B_valid and step_err low.
REQ-019 In TRACK with bn == (B+1) mod 2^W, SHALL load B <= bn, set dir = 1, pulse B_valid.
REQ-020 In TRACK with bn == (B-1) mod 2^W, SHALL load B <= bn, set dir = 0, pulse B_valid.
REQ-021 Wrap-around SHALL be legal: 2^W-1 -> 0 is up, 0 -> 2^W-1 is down.
REQ-022 In TRACK with any other bn, SHALL load B <= bn (resync), pulse B_valid and step_err together, hold dir, increment err_cnt.
REQ-023 err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 clr_err SHALL set err_cnt to 0 next cycle; if coincident with an illegal change, clear SHALL win (err_cnt = 0), step_err still pulses.
REQ-025 Latency: a stable change on G SHALL appear on B exactly SYNC_STAGES+1 cycles after the first clk edge sampling it.
REQ-026 B_valid and step_err SHALL be high for exactly one cycle per event; back-to-back events SHALL produce back-to-back pulses.

Reset
REQ-027 On rst_n low, SHALL asynchronously set sync flops 0, B 0, B_valid 0, dir 0, step_err 0, err_cnt 0, locked 0, fill counter 0, state INIT.
REQ-028 Reset asserted mid-operation SHALL abort immediately; after release the block SHALL repeat INIT fill with no step_err for the first loaded value.
REQ-029 Reset release SHALL be the only path back to INIT.

Structure
REQ-030 A shared package gray_pkg SHALL hold the default W, the FSM state enum (INIT, TRACK) and the SYNC_STAGES legal-range constants.
REQ-031 Gray-to-binary decode SHALL be a separate combinational sub-module gray2bin (parameter W), reused by the bench as reference model.
REQ-032 Total RTL SHALL be a single clock domain; no latches, no combinational outputs.

Verification
REQ-033 Reset release with G = 4'b0110 held -> after SYNC_STAGES+1 cycles B = 4, B_valid pulse, locked = 1, step_err = 0.
REQ-034 Drive G through Gray sequence for 0..15 then 0, one step per 4 cycles -> 16 B_valid pulses, dir = 1, 15 -> 0 legal, err_cnt = 0.
REQ-035 From B = 5 (G = 0111) jump G to 1100 (binary 8) -> B = 8, step_err and B_valid pulse same cycle, err_cnt = 1, dir unchanged.
REQ-036 Force 260 illegal jumps with CNT_W = 8 -> err_cnt = 255 held; then clr_err coincident with one more illegal jump -> err_cnt = 0, step_err pulses.
REQ-037 Assert rst_n low mid-sweep at B = 9 -> all outputs 0 asynchronously; release with G = Gray(12) -> B = 12 after fill, no step_err.
REQ-038 Down sweep from 0 (G = 0000 -> 1000) -> B = 15, dir = 0, no step_err.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and FSM state type for the Gray position tracker.
// Holds the default word width, the synchronizer depth range and the state enum.
package gray_pkg;

    localparam int unsigned GRAY_W_DEFAULT  = 4;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    // Wide enough to count 0..SYNC_STAGES_MAX.
    localparam int unsigned FILL_W          = 3;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin
    import gray_pkg::*;
#(
    parameter int unsigned W = GRAY_W_DEFAULT
) (
    input  logic [W-1:0] g,
    output logic [W-1:0] b
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign b[i] = ^g[W-1:i];
    end

endmodule

// File: rtl/gray_track_monitor.sv
// Synchronizes an asynchronous Gray position word, decodes it, and tracks legal
// single steps (with wrap), flagging and counting multi-step jumps.
module gray_track_monitor
    import gray_pkg::*;
#(
    parameter int unsigned W           = GRAY_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     G,
    input  logic             clr_err,
    output logic [W-1:0]     B,
    output logic             B_valid,
    output logic             dir,
    output logic             step_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             locked
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("gray_track_monitor: SYNC_STAGES out of legal range");
    end

    logic [W-1:0]      sync_q [SYNC_STAGES];
    logic [W-1:0]      gs;
    logic [W-1:0]      bn;
    state_t            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [W-1:0]      b_d;
    logic              b_valid_d, dir_d, step_err_d, locked_d;
    logic [CNT_W-1:0]  err_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= G;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign gs = sync_q[SYNC_STAGES-1];

    gray2bin #(.W(W)) u_gray2bin (
        .g (gs),
        .b (bn)
    );

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        b_d        = B;
        b_valid_d  = 1'b0;
        dir_d      = dir;
        step_err_d = 1'b0;
        locked_d   = locked;
        unique case (state_q)
            INIT: begin
                // Wait until the synchronizer holds only post-reset samples.
                if (fill_q == FILL_W'(SYNC_STAGES)) begin
                    b_d       = bn;
                    b_valid_d = 1'b1;
                    locked_d  = 1'b1;
                    state_d   = TRACK;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            TRACK: begin
                if (bn != B) begin
                    b_d       = bn;
                    b_valid_d = 1'b1;
                    if (bn == B + W'(1)) begin
                        dir_d = 1'b1;
                    end else if (bn == B - W'(1)) begin
                        dir_d = 1'b0;
                    end else begin
                        step_err_d = 1'b1;
                    end
                end
            end
        endcase

        if (clr_err) begin
            err_cnt_d = '0;
        end else if (step_err_d && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt + 1'b1;
        end else begin
            err_cnt_d = err_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            fill_q   <= '0;
            B        <= '0;
            B_valid  <= 1'b0;
            dir      <= 1'b0;
            step_err <= 1'b0;
            err_cnt  <= '0;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            B        <= b_d;
            B_valid  <= b_valid_d;
            dir      <= dir_d;
            step_err <= step_err_d;
            err_cnt  <= err_cnt_d;
            locked   <= locked_d;
        end
    end

endmodule
